adder_wc_pipe: RTL

- Wc-lane saturating vector adder: P = Q + R per lane. Each lane is a W-bit two's-complement value.
- Inverse of the existing per-layer subtraction (Q = P - R). It writes updated posterior LLRs back after the check-node update in the layered LDPC decoder.
- Two-stage pipeline with valid/ready backpressure on both sides.
- A tag carried alongside each data word identifies the layer and block column for the writeback address.

---
 rtl/ldpc_pkg.sv | 18 +
 rtl/sat_add_lane.sv | 32 +++
 rtl/adder_wc_pipe.sv | 109 ++++++++++
 3 files changed

// File: rtl/ldpc_pkg.sv
// Shared constants and helpers for the layered LDPC datapath blocks.
package ldpc_pkg;

  localparam int W_DEF    = 10;
  localparam int WC_DEF   = 32;
  localparam int TAGW_DEF = 8;

  // Largest magnitude an LLR may take; the range is kept symmetric around zero.
  function automatic int llr_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Low bit index of lane i in a packed vector of w-bit lanes.
  function automatic int lane_lo(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/sat_add_lane.sv
// One lane: widened two's-complement add, and symmetric clip of a registered sum.
module sat_add_lane
  import ldpc_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic signed [W-1:0] q,
  input  logic signed [W-1:0] r,
  output logic signed [W:0]   sum,
  input  logic signed [W:0]   sum_r,
  output logic signed [W-1:0] s,
  output logic                sat
);

  localparam logic signed [W:0] SMAX = (W+1)'(llr_max(W));
  localparam logic signed [W:0] SMIN = -SMAX;

  assign sum = {q[W-1], q} + {r[W-1], r};

  always_comb begin
    sat = 1'b0;
    s   = sum_r[W-1:0];
    if (sum_r > SMAX) begin
      s   = SMAX[W-1:0];
      sat = 1'b1;
    end else if (sum_r < SMIN) begin
      s   = SMIN[W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/adder_wc_pipe.sv
// Two-stage Wc-lane saturating adder (P = Q + R) with valid/ready and a sideband tag.
// Optional saturation counter is enabled with `define ADDER_WC_SATCNT_EN.
module adder_wc_pipe
  import ldpc_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int Wc   = WC_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [Wc*W-1:0]   X,
  input  logic [Wc*W-1:0]   Y,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Wc*W-1:0]   S,
  output logic [Wc-1:0]     sat,
  output logic [TAGW-1:0]   out_tag
`ifdef ADDER_WC_SATCNT_EN
  ,
  input  logic              sat_clr,
  output logic [15:0]       sat_cnt
`endif
);

  localparam int SW = W + 1;

  logic                s1_valid;
  logic [Wc*SW-1:0]    s1_sum;
  logic [TAGW-1:0]     s1_tag;
  logic [Wc*SW-1:0]    lane_sum;
  logic [Wc*W-1:0]     lane_s;
  logic [Wc-1:0]       lane_sat;
  logic                s1_adv;
  logic                s2_adv;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  for (genvar i = 0; i < Wc; i++) begin : g_lane
    sat_add_lane #(.W(W)) u_lane (
      .q     (X[lane_lo(i, W) +: W]),
      .r     (Y[lane_lo(i, W) +: W]),
      .sum   (lane_sum[lane_lo(i, SW) +: SW]),
      .sum_r (s1_sum[lane_lo(i, SW) +: SW]),
      .s     (lane_s[lane_lo(i, W) +: W]),
      .sat   (lane_sat[i])
    );
  end

  // When s1 advances its old word (if any) has moved on, so validity follows in_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum <= lane_sum;
        s1_tag <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      S         <= '0;
      sat       <= '0;
      out_tag   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        S       <= lane_s;
        sat     <= lane_sat;
        out_tag <= s1_tag;
      end
    end
  end

`ifdef ADDER_WC_SATCNT_EN
  logic [15:0] sat_pop;
  logic [16:0] sat_nxt;

  always_comb begin
    sat_pop = '0;
    for (int unsigned i = 0; i < Wc; i++) begin
      sat_pop = sat_pop + 16'(sat[i]);
    end
    sat_nxt = {1'b0, sat_cnt} + {1'b0, sat_pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      sat_cnt <= sat_nxt[16] ? '1 : sat_nxt[15:0];
    end
  end
`endif

endmodule
